// File: rtl/sram_actmem_banked_pkg.sv
// Shared defaults and types for the banked activation-memory SRAM.
// Widths follow the default CUTIE configuration; modules override them through parameters.
package sram_actmem_pkg;

  localparam int unsigned DEF_NUM_BANKS    = 6;
  localparam int unsigned DEF_NUM_WORDS    = 1024;
  localparam int unsigned DEF_DATA_WIDTH   = 40;
  localparam int unsigned DEF_ADDR_WIDTH   = $clog2(DEF_NUM_WORDS);
  localparam int unsigned MAX_READ_LATENCY = 4;

  typedef logic [DEF_ADDR_WIDTH-1:0] bank_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] bank_word_t;

  typedef struct packed {
    logic       req;
    logic       we;
    bank_addr_t addr;
    bank_word_t wdata;
    bank_word_t be;
  } bank_req_t;

  // Pipeline depth is held to the supported 1..MAX_READ_LATENCY window.
  function automatic int unsigned clamp_latency(int unsigned lat);
    if (lat < 1) return 1;
    if (lat > MAX_READ_LATENCY) return MAX_READ_LATENCY;
    return lat;
  endfunction

endpackage

// File: rtl/sram_actmem_banked_if.sv
// Per-bank request/response bundle of the banked activation-memory SRAM.
interface sram_actmem_banked_if #(
  parameter int unsigned NUM_BANKS  = sram_actmem_pkg::DEF_NUM_BANKS,
  parameter int unsigned ADDR_WIDTH = sram_actmem_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = sram_actmem_pkg::DEF_DATA_WIDTH
);
  logic                                  flush_i;
  logic [NUM_BANKS-1:0]                  req_i;
  logic [NUM_BANKS-1:0]                  we_i;
  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]  addr_i;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  wdata_i;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  be_i;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  rdata_o;
  logic [NUM_BANKS-1:0]                  rvalid_o;
  logic                                  err_o;

  modport master (
    output flush_i, req_i, we_i, addr_i, wdata_i, be_i,
    input  rdata_o, rvalid_o, err_o
  );

  modport slave (
    input  flush_i, req_i, we_i, addr_i, wdata_i, be_i,
    output rdata_o, rvalid_o, err_o
  );
endinterface

// File: rtl/sram_actmem_banked_bank.sv
// One SRAM bank: bit-masked write, latency-configurable read pipeline with flush.
// Optional sticky range-error flag under SRAM_ACTMEM_BOUNDS_CHECK_EN.
module sram_actmem_bank
  import sram_actmem_pkg::*;
#(
  parameter int unsigned NUM_WORDS     = DEF_NUM_WORDS,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned READ_LATENCY  = 1,
  parameter bit          WRITE_THROUGH = 1'b0,
  parameter int unsigned ADDR_WIDTH    = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] be_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o
);
  localparam int unsigned LAT = clamp_latency(READ_LATENCY);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t          mem_q [NUM_WORDS];
  logic           in_range;
  word_t          rd_word;
  word_t          merged;
  word_t          resp_data;
  logic           resp_valid;
  logic [LAT-1:0] vld_q, vld_d;
  word_t          dat_q [LAT];
  word_t          dat_d [LAT];

  assign in_range = (32'(addr_i) < NUM_WORDS);
  assign rd_word  = in_range ? mem_q[addr_i] : '0;

  always_comb begin
    merged     = (rd_word & ~be_i) | (wdata_i & be_i);
    resp_valid = req_i && !flush_i && (!we_i || WRITE_THROUGH);
    resp_data  = !in_range ? '0 : (we_i ? merged : rd_word);
    vld_d      = vld_q;
    dat_d      = dat_q;
    // Each stage only loads on a live token, so the last stage holds its value between responses.
    vld_d[0]   = resp_valid;
    dat_d[0]   = resp_valid ? resp_data : dat_q[0];
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1] && !flush_i;
      dat_d[i] = vld_d[i] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (req_i && we_i && in_range) mem_q[addr_i] <= merged;
  end

  assign rvalid_o = vld_q[LAT-1];
  assign rdata_o  = dat_q[LAT-1];

`ifdef SRAM_ACTMEM_BOUNDS_CHECK_EN
  logic err_q, err_d;

  assign err_d = err_q | (req_i & ~in_range);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/sram_actmem_banked.sv
// Multi-bank activation-memory SRAM: NUM_BANKS independent single-port banks.
// Define SRAM_ACTMEM_BOUNDS_CHECK_EN for the sticky out-of-range error flag and report.
module sram_actmem_banked
  import sram_actmem_pkg::*;
#(
  parameter int unsigned NUM_BANKS     = DEF_NUM_BANKS,
  parameter int unsigned NUM_WORDS     = DEF_NUM_WORDS,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned READ_LATENCY  = 1,
  parameter bit          WRITE_THROUGH = 1'b0,
  parameter int unsigned ADDR_WIDTH    = $clog2(NUM_WORDS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sram_actmem_banked_if.slave  bus
);
  logic [NUM_BANKS-1:0]                 rvalid;
  logic [NUM_BANKS-1:0]                 err;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rdata;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sram_actmem_bank #(
      .NUM_WORDS    (NUM_WORDS),
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY),
      .WRITE_THROUGH(WRITE_THROUGH),
      .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_bank (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (bus.flush_i),
      .req_i   (bus.req_i[b]),
      .we_i    (bus.we_i[b]),
      .addr_i  (bus.addr_i[b]),
      .wdata_i (bus.wdata_i[b]),
      .be_i    (bus.be_i[b]),
      .rdata_o (rdata[b]),
      .rvalid_o(rvalid[b]),
      .err_o   (err[b])
    );

`ifdef SRAM_ACTMEM_BOUNDS_CHECK_EN
    always_ff @(posedge clk_i) begin
      if (!rst_i && bus.req_i[b]) begin
        assert (32'(bus.addr_i[b]) < NUM_WORDS)
          else $error("sram_actmem_banked: bank %0d address %0d out of range", b, bus.addr_i[b]);
      end
    end
`endif
  end

  assign bus.rdata_o  = rdata;
  assign bus.rvalid_o = rvalid;
  assign bus.err_o    = |err;

endmodule

// File: tb/tb_sram_actmem_banked.sv
// Randomised bench for sram_actmem_banked against a queue-based reference model.
// Two instances: 6 banks / latency 3 / no write-through, and 2 banks / 1000 words / latency 1 / write-through.
module tb_sram_actmem_banked;
  localparam int unsigned NB_A = 6, NW_A = 1024, LAT_A = 3;
  localparam int unsigned NB_B = 2, NW_B = 1000, LAT_B = 1;
  localparam int unsigned DW = 40, AW = 10;

  typedef logic [DW-1:0] word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_actmem_banked_if #(.NUM_BANKS(NB_A), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  sram_actmem_banked_if #(.NUM_BANKS(NB_B), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  sram_actmem_banked #(
    .NUM_BANKS(NB_A), .NUM_WORDS(NW_A), .DATA_WIDTH(DW),
    .READ_LATENCY(LAT_A), .WRITE_THROUGH(1'b0)
  ) u_dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));

  sram_actmem_banked #(
    .NUM_BANKS(NB_B), .NUM_WORDS(NW_B), .DATA_WIDTH(DW),
    .READ_LATENCY(LAT_B), .WRITE_THROUGH(1'b1)
  ) u_dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc   = 0;

  // Reference model: sparse memory plus per-bank queues of (due edge, data).
  word_t mem_m [int];
  int    dueq  [2][6][$];
  word_t datq  [2][6][$];
  logic  exp_v [2][6];
  word_t exp_d [2][6];
  logic  exp_err [2];

  function automatic int nbanks(input int d);
    return (d == 0) ? int'(NB_A) : int'(NB_B);
  endfunction

  function automatic void observe(input int d, input int b, output logic v, output word_t w);
    if (d == 0) begin v = bus_a.rvalid_o[b]; w = bus_a.rdata_o[b]; end
    else        begin v = bus_b.rvalid_o[b]; w = bus_b.rdata_o[b]; end
  endfunction

  function automatic logic observe_err(input int d);
    return (d == 0) ? bus_a.err_o : bus_b.err_o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_err[d] = 1'b0;
      for (int b = 0; b < 6; b++) begin
        dueq[d][b].delete();
        datq[d][b].delete();
        exp_v[d][b] = 1'b0;
        exp_d[d][b] = '0;
      end
    end
  endtask

  task automatic model_edge(input int d, input int nb, input int nw, input int lat, input bit wt,
                            input logic fl, input logic [5:0] rq, input logic [5:0] we,
                            input logic [5:0][AW-1:0] ad, input logic [5:0][DW-1:0] wd,
                            input logic [5:0][DW-1:0] be);
    for (int b = 0; b < nb; b++) begin
      int    key;
      bit    ok;
      word_t old_w, new_w;
      key   = d * 65536 + b * 2048 + int'(ad[b]);
      ok    = int'(ad[b]) < nw;
      old_w = (ok && mem_m.exists(key)) ? mem_m[key] : '0;
      if (rq[b]) begin
        if (!we[b]) begin
          dueq[d][b].push_back(cyc + lat - 1);
          datq[d][b].push_back(ok ? old_w : '0);
        end else begin
          new_w = (old_w & ~be[b]) | (wd[b] & be[b]);
          if (ok) mem_m[key] = new_w;
          if (wt) begin
            dueq[d][b].push_back(cyc + lat - 1);
            datq[d][b].push_back(ok ? new_w : '0);
          end
        end
`ifdef SRAM_ACTMEM_BOUNDS_CHECK_EN
        if (!ok) exp_err[d] = 1'b1;
`endif
      end
      if (fl) begin
        dueq[d][b].delete();
        datq[d][b].delete();
      end
      exp_v[d][b] = 1'b0;
      if (dueq[d][b].size() > 0 && dueq[d][b][0] == cyc) begin
        exp_v[d][b] = 1'b1;
        exp_d[d][b] = datq[d][b].pop_front();
        void'(dueq[d][b].pop_front());
      end
    end
  endtask

  // Advance one clock: model the edge, then return at the falling edge to sample and drive.
  task automatic step();
    logic [5:0]         rq, we;
    logic [5:0][AW-1:0] ad;
    logic [5:0][DW-1:0] wd, be;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      model_edge(0, NB_A, NW_A, LAT_A, 1'b0, bus_a.flush_i, bus_a.req_i, bus_a.we_i,
                 bus_a.addr_i, bus_a.wdata_i, bus_a.be_i);
      rq = '0; we = '0; ad = '0; wd = '0; be = '0;
      for (int b = 0; b < int'(NB_B); b++) begin
        rq[b] = bus_b.req_i[b];  we[b] = bus_b.we_i[b];  ad[b] = bus_b.addr_i[b];
        wd[b] = bus_b.wdata_i[b]; be[b] = bus_b.be_i[b];
      end
      model_edge(1, NB_B, NW_B, LAT_B, 1'b1, bus_b.flush_i, rq, we, ad, wd, be);
    end
    @(negedge clk);
  endtask

  task automatic idle_all();
    bus_a.flush_i = 1'b0; bus_a.req_i = '0; bus_a.we_i = '0;
    bus_a.addr_i  = '0;   bus_a.wdata_i = '0; bus_a.be_i = '0;
    bus_b.flush_i = 1'b0; bus_b.req_i = '0; bus_b.we_i = '0;
    bus_b.addr_i  = '0;   bus_b.wdata_i = '0; bus_b.be_i = '0;
  endtask

  function automatic word_t rand_word();
    return {8'($urandom()), $urandom()};
  endfunction

  task automatic test_reset();
    logic ov; word_t od;
    rst = 1'b1;
    idle_all();
    #2;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        if (k == 3) rst = 1'b0;
        step();
      end
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (observe_err(d) !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_err dut%0d: got %b, want 0", d, observe_err(d));
        end
        for (int b = 0; b < nbanks(d); b++) begin
          observe(d, b, ov, od);
          n_cmp++;
          if (ov !== 1'b0 || od !== '0) begin
            n_bad++;
            $display("FAIL reset dut%0d bank%0d step%0d: got v=%b d=%h, want v=0 d=0", d, b, k, ov, od);
          end
        end
      end
    end
  endtask

  task automatic test_latency();
    logic ov; word_t od;
    int first, pulses;
    idle_all();
    bus_a.req_i[2] = 1'b1; bus_a.we_i[2] = 1'b1; bus_a.addr_i[2] = 10'd5;
    bus_a.wdata_i[2] = 40'h12_3456_789A; bus_a.be_i[2] = '1;
    step();
    idle_all();
    bus_a.req_i[2] = 1'b1; bus_a.addr_i[2] = 10'd5;
    first = 0; pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) idle_all();
      for (int d = 0; d < 2; d++)
        for (int b = 0; b < nbanks(d); b++) begin
          observe(d, b, ov, od);
          n_cmp++;
          if (ov !== exp_v[d][b] || od !== exp_d[d][b]) begin
            n_bad++;
            $display("FAIL latency dut%0d bank%0d cyc%0d: got v=%b d=%h, want v=%b d=%h",
                     d, b, cyc, ov, od, exp_v[d][b], exp_d[d][b]);
          end
        end
      if (bus_a.rvalid_o[2] === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    n_cmp++;
    if (first != int'(LAT_A) || pulses != 1) begin
      n_bad++;
      $display("FAIL latency_timing: got first=%0d pulses=%0d, want first=%0d pulses=1", first, pulses, LAT_A);
    end
    n_cmp++;
    if (bus_a.rdata_o[2] !== 40'h12_3456_789A) begin
      n_bad++;
      $display("FAIL latency_data: got %h, want 123456789a", bus_a.rdata_o[2]);
    end
  endtask

  task automatic test_bitmask();
    logic ov; word_t od;
    word_t wv [3];
    word_t bv [3];
    wv[0] = '1; bv[0] = '1;
    wv[1] = '0; bv[1] = 40'h00_0000_FFFF;
    wv[2] = '0; bv[2] = '0;
    for (int n = 0; n < 3; n++) begin
      idle_all();
      bus_a.req_i[0] = 1'b1; bus_a.we_i[0] = 1'b1; bus_a.addr_i[0] = 10'd7;
      bus_a.wdata_i[0] = wv[n]; bus_a.be_i[0] = bv[n];
      step();
      idle_all();
      bus_a.req_i[0] = 1'b1; bus_a.addr_i[0] = 10'd7;
      for (int k = 0; k < int'(LAT_A); k++) begin
        step();
        idle_all();
        for (int b = 0; b < int'(NB_A); b++) begin
          observe(0, b, ov, od);
          n_cmp++;
          if (ov !== exp_v[0][b] || od !== exp_d[0][b]) begin
            n_bad++;
            $display("FAIL bitmask bank%0d cyc%0d: got v=%b d=%h, want v=%b d=%h",
                     b, cyc, ov, od, exp_v[0][b], exp_d[0][b]);
          end
        end
      end
      if (n > 0) begin
        n_cmp++;
        if (bus_a.rvalid_o[0] !== 1'b1 || bus_a.rdata_o[0] !== 40'hFF_FFFF_0000) begin
          n_bad++;
          $display("FAIL bitmask_word write%0d: got v=%b d=%h, want v=1 d=ffffff0000",
                   n, bus_a.rvalid_o[0], bus_a.rdata_o[0]);
        end
      end
    end
  endtask

  task automatic test_throughput();
    logic ov; word_t od;
    int cnt [6];
    int fst [6];
    int lst [6];
    for (int a = 0; a < 100; a++) begin
      for (int b = 0; b < int'(NB_A); b++) begin
        bus_a.req_i[b] = 1'b1; bus_a.we_i[b] = 1'b1; bus_a.addr_i[b] = 10'(a);
        bus_a.wdata_i[b] = rand_word(); bus_a.be_i[b] = '1;
      end
      step();
    end
    idle_all();
    for (int b = 0; b < 6; b++) begin cnt[b] = 0; fst[b] = -1; lst[b] = -1; end
    for (int a = 0; a < 100 + int'(LAT_A); a++) begin
      if (a < 100) begin
        bus_a.req_i = '1; bus_a.we_i = '0;
        for (int b = 0; b < int'(NB_A); b++) bus_a.addr_i[b] = 10'(a);
      end else begin
        idle_all();
      end
      step();
      for (int b = 0; b < int'(NB_A); b++) begin
        observe(0, b, ov, od);
        n_cmp++;
        if (ov !== exp_v[0][b] || od !== exp_d[0][b]) begin
          n_bad++;
          $display("FAIL throughput bank%0d cyc%0d: got v=%b d=%h, want v=%b d=%h",
                   b, cyc, ov, od, exp_v[0][b], exp_d[0][b]);
        end
        if (ov === 1'b1) begin
          cnt[b]++;
          if (fst[b] < 0) fst[b] = a;
          lst[b] = a;
        end
      end
    end
    for (int b = 0; b < int'(NB_A); b++) begin
      n_cmp++;
      if (cnt[b] != 100 || lst[b] - fst[b] != 99) begin
        n_bad++;
        $display("FAIL throughput_count bank%0d: got %0d responses over span %0d, want 100 over 99",
                 b, cnt[b], lst[b] - fst[b]);
      end
    end
  endtask

  task automatic test_flush();
    logic ov; word_t od;
    word_t held, wnew;
    int    seen;
    idle_all();
    held = bus_a.rdata_o[1];
    wnew = rand_word();
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      idle_all();
      if (k < 2) begin
        bus_a.req_i[1] = 1'b1; bus_a.addr_i[1] = 10'(10 + k);
      end
      if (k == 1) begin
        bus_a.flush_i  = 1'b1;
        bus_a.req_i[3] = 1'b1; bus_a.we_i[3] = 1'b1; bus_a.addr_i[3] = 10'd20;
        bus_a.wdata_i[3] = wnew; bus_a.be_i[3] = '1;
      end
      if (k == 3) begin
        bus_a.req_i[3] = 1'b1; bus_a.addr_i[3] = 10'd20;
      end
      step();
      if (bus_a.rvalid_o[1] === 1'b1) seen++;
      for (int b = 0; b < int'(NB_A); b++) begin
        observe(0, b, ov, od);
        n_cmp++;
        if (ov !== exp_v[0][b] || od !== exp_d[0][b]) begin
          n_bad++;
          $display("FAIL flush bank%0d cyc%0d: got v=%b d=%h, want v=%b d=%h",
                   b, cyc, ov, od, exp_v[0][b], exp_d[0][b]);
        end
      end
    end
    idle_all();
    n_cmp++;
    if (seen != 0 || bus_a.rdata_o[1] !== held) begin
      n_bad++;
      $display("FAIL flush_hold: got %0d pulses d=%h, want 0 pulses d=%h", seen, bus_a.rdata_o[1], held);
    end
    n_cmp++;
    if (bus_a.rdata_o[3] !== wnew) begin
      n_bad++;
      $display("FAIL flush_write: got %h, want %h", bus_a.rdata_o[3], wnew);
    end
  endtask

  task automatic test_reset_mid();
    logic ov; word_t od;
    for (int k = 0; k < 2; k++) begin
      idle_all();
      bus_a.req_i[4] = 1'b1; bus_a.addr_i[4] = 10'(30 + k);
      step();
    end
    idle_all();
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 8 + int'(LAT_A); k++) begin
      if (k > 0) step();
      if (k == 2) rst = 1'b0;
      if (k == 5) begin bus_a.req_i[4] = 1'b1; bus_a.addr_i[4] = 10'd30; end
      if (k == 6) idle_all();
      for (int b = 0; b < int'(NB_A); b++) begin
        observe(0, b, ov, od);
        n_cmp++;
        if (ov !== exp_v[0][b] || od !== exp_d[0][b]) begin
          n_bad++;
          $display("FAIL reset_mid bank%0d step%0d: got v=%b d=%h, want v=%b d=%h",
                   b, k, ov, od, exp_v[0][b], exp_d[0][b]);
        end
      end
    end
  endtask

  task automatic test_write_through_bounds();
    logic ov; word_t od;
    for (int k = 0; k < 24; k++) begin
      idle_all();
      if (k < 16) begin
        bus_b.req_i = '1; bus_b.we_i = '1;
        for (int b = 0; b < int'(NB_B); b++) begin
          bus_b.addr_i[b] = 10'(k); bus_b.wdata_i[b] = rand_word(); bus_b.be_i[b] = '1;
        end
      end
      if (k == 16) begin
        bus_b.req_i[1] = 1'b1; bus_b.we_i[1] = 1'b1; bus_b.addr_i[1] = 10'd3;
        bus_b.wdata_i[1] = rand_word(); bus_b.be_i[1] = rand_word();
      end
      if (k == 18) begin bus_b.req_i[0] = 1'b1; bus_b.addr_i[0] = 10'd1000; end
      if (k == 20) begin
        bus_b.req_i[0] = 1'b1; bus_b.we_i[0] = 1'b1; bus_b.addr_i[0] = 10'd1001;
        bus_b.wdata_i[0] = '1; bus_b.be_i[0] = '1;
      end
      step();
      for (int b = 0; b < int'(NB_B); b++) begin
        observe(1, b, ov, od);
        n_cmp++;
        if (ov !== exp_v[1][b] || od !== exp_d[1][b]) begin
          n_bad++;
          $display("FAIL wt_bounds bank%0d step%0d: got v=%b d=%h, want v=%b d=%h",
                   b, k, ov, od, exp_v[1][b], exp_d[1][b]);
        end
      end
      n_cmp++;
      if (bus_b.err_o !== exp_err[1]) begin
        n_bad++;
        $display("FAIL bounds_err step%0d: got %b, want %b", k, bus_b.err_o, exp_err[1]);
      end
      if (k == 18) begin
        n_cmp++;
        if (bus_b.rvalid_o[0] !== 1'b1 || bus_b.rdata_o[0] !== '0) begin
          n_bad++;
          $display("FAIL bounds_read: got v=%b d=%h, want v=1 d=0", bus_b.rvalid_o[0], bus_b.rdata_o[0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic ov; word_t od;
    for (int n = 0; n < 400 + 4; n++) begin
      idle_all();
      if (n < 400) begin
        bus_a.flush_i = ($urandom_range(0, 15) == 0);
        bus_b.flush_i = ($urandom_range(0, 15) == 0);
        for (int b = 0; b < int'(NB_A); b++) begin
          bus_a.req_i[b]   = 1'($urandom_range(0, 1));
          bus_a.we_i[b]    = ($urandom_range(0, 2) == 0);
          bus_a.addr_i[b]  = 10'($urandom_range(0, 99));
          bus_a.wdata_i[b] = rand_word();
          bus_a.be_i[b]    = rand_word();
        end
        for (int b = 0; b < int'(NB_B); b++) begin
          bus_b.req_i[b]   = 1'($urandom_range(0, 1));
          bus_b.we_i[b]    = ($urandom_range(0, 2) == 0);
          bus_b.addr_i[b]  = ($urandom_range(0, 7) == 0) ? 10'(1000 + $urandom_range(0, 23))
                                                         : 10'($urandom_range(0, 15));
          bus_b.wdata_i[b] = rand_word();
          bus_b.be_i[b]    = rand_word();
        end
      end
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (observe_err(d) !== exp_err[d]) begin
          n_bad++;
          $display("FAIL random_err dut%0d cyc%0d: got %b, want %b", d, cyc, observe_err(d), exp_err[d]);
        end
        for (int b = 0; b < nbanks(d); b++) begin
          observe(d, b, ov, od);
          n_cmp++;
          if (ov !== exp_v[d][b] || od !== exp_d[d][b]) begin
            n_bad++;
            $display("FAIL random dut%0d bank%0d cyc%0d: got v=%b d=%h, want v=%b d=%h",
                     d, b, cyc, ov, od, exp_v[d][b], exp_d[d][b]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bitmask();
    test_throughput();
    test_flush();
    test_reset_mid();
    test_write_through_bounds();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_actmem_banked.md
Name: sram_actmem_banked

Overview:
- Parametrised, multi-bank, single-port-per-bank behavioural SRAM for the activation memory. It is the successor to the single-bank actmem model.
- Holds NUM_BANKS independent banks. Each bank has its own request, address, per-bit write enable and read data.
- Read latency is configurable and carries an explicit read-valid. A flush input drops in-flight reads.
- Sits between the actmem controller / linebuffer fetch logic and the trit decoders. It is used in simulation and in FPGA emulation.

Parameters:
- NUM_BANKS, 6, number of independent banks (K*WEIGHT_STAGGER for the default CUTIE configuration).
- NUM_WORDS, 1024, words per bank; need not be a power of two.
- DATA_WIDTH, 40, bits per word (PHYSICALBITSPERWORD).
- READ_LATENCY, 1, cycles from accepted read to rvalid; legal range 1..4.
- WRITE_THROUGH, 0. 0: a write produces no read response. 1: a write also returns the merged new word with rvalid, same latency as a read.
- ADDR_WIDTH, $clog2(NUM_WORDS), derived; not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous; kills all in-flight read responses
- req_i  in  NUM_BANKS  per-bank request
- we_i  in  NUM_BANKS  per-bank write enable; 1 = write, 0 = read
- addr_i  in  NUM_BANKS x ADDR_WIDTH  per-bank word address
- wdata_i  in  NUM_BANKS x DATA_WIDTH  per-bank write data
- be_i  in  NUM_BANKS x DATA_WIDTH  per-bit write enable
- rdata_o  out  NUM_BANKS x DATA_WIDTH  per-bank read data
- rvalid_o  out  NUM_BANKS  per-bank read data valid
- err_o  out  1  sticky error flag; only present with the optional feature, otherwise tied 0

Behaviour:
- Reset (async assert of rst_i):
  - Per-bank valid pipeline and data pipeline cleared.
  - rvalid_o = 0 and rdata_o = 0 while reset is asserted and on the first edge after it.
  - err_o = 0.
  - Memory array is not reset; contents persist across reset.
- Banks are fully independent: no arbitration, no stalls; every request is accepted in the cycle it is presented.
- Read: req_i[b]=1 and we_i[b]=0 at edge t. The word at addr_i[b] is sampled at edge t. rdata_o[b] is valid with rvalid_o[b]=1 during the cycle after edge t+READ_LATENCY-1. READ_LATENCY=1 gives a registered output in the next cycle.
- Pipelining: back-to-back reads on every cycle are allowed. The pipeline is READ_LATENCY deep per bank; responses come back in order, one per cycle.
- Write: req_i[b]=1 and we_i[b]=1 at edge t. For each bit i with be_i[b][i]=1, mem[b][addr][i] <= wdata_i[b][i]; bits with be_i=0 are unchanged. be_i=0 everywhere is a legal no-op write.
- A write with WRITE_THROUGH=0 produces no rvalid. A write with WRITE_THROUGH=1 returns the merged word (new bits where be=1, old bits elsewhere) with the read latency.
- Read after write to the same bank and address at edge t+1 returns the new data.
- Output hold: when rvalid_o[b]=0, rdata_o[b] holds its last valid value. It never goes X and is never driven from unread memory.
- Unwritten memory words read X in simulation. This is the only X source.
- flush_i=1 at edge t:
  - All valid bits in every bank pipeline are cleared, so no rvalid from any request accepted at or before edge t.
  - A request presented in the same cycle as flush_i is also dropped for reads.
  - Writes in the flush cycle still commit.
- Reset mid-read: pending responses are discarded; no rvalid after reset deasserts.
- Address >= NUM_WORDS:
  - Read returns rdata = 0 with rvalid still asserted.
  - Write is suppressed.

Optional Feature:
- Macro: SRAM_ACTMEM_BOUNDS_CHECK_EN
- Defined:
  - err_o is set at the edge after any request with addr_i[b] >= NUM_WORDS. It stays set until rst_i.
  - A simulation $error is also issued with bank index and address.
- Undefined:
  - No checker logic; err_o is tied 0.
  - Out-of-range behaviour stays as in the Behaviour section.

Decomposition:
- Package sram_actmem_pkg:
  - MAX_READ_LATENCY = 4.
  - Typedefs: bank address (logic [ADDR_WIDTH-1:0]), bank word (logic [DATA_WIDTH-1:0]), per-bank request struct {req, we, addr, wdata, be}.
  - Read size from cutie_params defaults.
- One sub-module, sram_actmem_bank: a single bank containing the memory array, bit-masked write and the READ_LATENCY-deep valid/data pipeline with flush.
- Top level generates NUM_BANKS instances and ORs the per-bank error flags.

Test Plan:
- Latency sweep: READ_LATENCY=3. Write 0x12_3456_789A to bank 2 addr 5, then read -> rvalid_o[2] pulses exactly 3 cycles after the read edge with 0x12_3456_789A; other banks show rvalid=0.
- Bit masking: write all ones, then write 0 with be=0x00_0000_FFFF -> read returns 0xFF_FFFF_0000.
- Throughput: 100 consecutive reads on all 6 banks at addresses 0..99 -> 100 in-order responses per bank, with no gaps in rvalid.
- Flush: issue reads at cycles 0 and 1 with READ_LATENCY=2, flush_i at cycle 1 -> no rvalid; rdata_o holds its prior value. A write in the flush cycle is visible on a later read.
- Reset mid-operation: rst_i pulsed while 2 reads are in flight -> rvalid_o and rdata_o read 0; memory content written before reset still reads back correctly.
- Bounds check (macro defined, NUM_WORDS=1000): read addr 1000 -> rdata 0 with rvalid, err_o=1 the next cycle and held. Without the macro, err_o stays 0.
